// File: rtl/status_flag_register.sv
// status_flag_register
//
// Producer side of the NZCV status path in the EXE stage. Derives N, Z, C, V
// from the current ALU operation and holds them in the architectural status
// register read by the condition-check logic. A one-entry shadow copy supports
// exception entry (save) and return (restore).
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   alu_cmd       EXE command code (selects arithmetic vs logical flag rules)
//   op_a, op_b    ALU operands (only the MSBs matter, for overflow)
//   alu_result    ALU result for the same instruction
//   alu_carry     ALU carry-out (for SUB/SBC: 1 = no borrow)
//   s_update      instruction valid with S bit set
//   freeze        pipeline stall; blocks every register write this cycle
//   exc_save      copy current status into shadow
//   exc_restore   copy shadow into status
//   status        registered {N,Z,C,V}
//   status_next   value status takes at the next edge
//   saved_status  registered shadow {N,Z,C,V}
//   flags_changed registered pulse: status changed at the last edge
`timescale 1ns/1ps

module status_flag_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             s_update,
    input  logic             freeze,
    input  logic             exc_save,
    input  logic             exc_restore,
    output logic [3:0]       status,
    output logic [3:0]       status_next,
    output logic [3:0]       saved_status,
    output logic             flags_changed
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_MVN = 4'b1001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000
    } alu_cmd_e;

    logic       add_type;
    logic       sub_type;
    logic       a_msb;
    logic       b_msb;
    logic       r_msb;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic [3:0] derived;
    logic [3:0] saved_next;

    // Only the operand sign bits feed the overflow rule; the rest is
    // deliberately ignored.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{op_a[WIDTH-2:0], op_b[WIDTH-2:0]};

    assign a_msb = op_a[WIDTH-1];
    assign b_msb = op_b[WIDTH-1];
    assign r_msb = alu_result[WIDTH-1];

    // Command decode. Any code outside the arithmetic group, including
    // undefined ones, follows the logical/move rule.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        add_type = 1'b0;
        sub_type = 1'b0;
        case (alu_cmd)
            CMD_ADD, CMD_ADC: add_type = 1'b1;
            CMD_SUB, CMD_SBC: sub_type = 1'b1;
            default: ;
        endcase
    end

    // Flag derivation. C and V on logical ops keep the registered value,
    // i.e. whatever the preceding edge wrote.
    always_comb begin
        flag_n = r_msb;
        flag_z = (alu_result == '0);
        flag_c = status[1];
        flag_v = status[0];
        if (add_type) begin
            flag_c = alu_carry;
            flag_v = (a_msb == b_msb) && (r_msb != a_msb);
        end else if (sub_type) begin
            flag_c = alu_carry;
            flag_v = (a_msb != b_msb) && (r_msb != a_msb);
        end
    end

    assign derived = {flag_n, flag_z, flag_c, flag_v};

    // Write-source selection; freeze dominates, then restore, then S update.
    always_comb begin
        status_next = status;
        if (freeze) begin
            status_next = status;
        end else if (exc_restore) begin
            status_next = saved_status;
        end else if (s_update) begin
            status_next = derived;
        end
    end

    // The shadow captures the pre-edge status, so save+restore in one cycle
    // swaps the two registers.
    always_comb begin
        saved_next = saved_status;
        if (!freeze && exc_save) begin
            saved_next = status;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which the swap behaviour depends on.
    // NOTE: the shadow is reset along with status; an exception return after
    // reset must not restore stale flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status        <= 4'b0000;
            saved_status  <= 4'b0000;
            flags_changed <= 1'b0;
        end else begin
            status        <= status_next;
            saved_status  <= saved_next;
            flags_changed <= (status_next != status) && !freeze;
        end
    end

endmodule

// File: tb/tb_status_flag_register.sv
// Directed self-checking bench for status_flag_register.
`timescale 1ns/1ps

module tb_status_flag_register;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             s_update;
    logic             freeze;
    logic             exc_save;
    logic             exc_restore;
    logic [3:0]       status;
    logic [3:0]       status_next;
    logic [3:0]       saved_status;
    logic             flags_changed;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0100;
    localparam logic [3:0] AND = 4'b0110;

    status_flag_register #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_cmd      (alu_cmd),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .s_update     (s_update),
        .freeze       (freeze),
        .exc_save     (exc_save),
        .exc_restore  (exc_restore),
        .status       (status),
        .status_next  (status_next),
        .saved_status (saved_status),
        .flags_changed(flags_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] observed,
                         input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r,
                          input logic c);
        alu_cmd    = cmd;
        op_a       = a;
        op_b       = b;
        alu_result = r;
        alu_carry  = c;
    endtask

    task automatic set_ctl(input logic s, input logic f, input logic sv,
                           input logic rs);
        s_update    = s;
        freeze      = f;
        exc_save    = sv;
        exc_restore = rs;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        set_op(4'b0000, '0, '0, '0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle();
        check("reset status", status, 4'b0000);
        check("reset saved", saved_status, 4'b0000);
        check("reset changed", {3'b000, flags_changed}, 4'b0000);
        rst = 1'b1;

        // ADD overflow: 0x7FFFFFFF + 1 -> N=1 V=1
        set_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("add next", status_next, 4'b1001);
        cycle();
        check("add status", status, 4'b1001);
        check("add changed", {3'b000, flags_changed}, 4'b0001);

        // SUB 5-5 -> Z=1 C=1
        set_op(SUB, 32'd5, 32'd5, 32'd0, 1'b1);
        #1 check("sub next", status_next, 4'b0110);
        cycle();
        check("sub status", status, 4'b0110);

        // AND keeps C=1 V=0 from the previous edge
        set_op(AND, 32'hFFFF_FFFF, 32'hF000_0000, 32'hF000_0000, 1'b0);
        #1 check("and next", status_next, 4'b1010);
        cycle();
        check("and status", status, 4'b1010);
        check("and changed", {3'b000, flags_changed}, 4'b0001);

        // ADD producing 0100 with s_update=0 -> hold
        set_op(ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("no s next", status_next, 4'b1010);
        cycle();
        check("no s status", status, 4'b1010);
        check("no s changed", {3'b000, flags_changed}, 4'b0000);

        // Same ADD frozen with s_update=1 -> hold
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("freeze next", status_next, 4'b1010);
        cycle();
        check("freeze status", status, 4'b1010);
        check("freeze changed", {3'b000, flags_changed}, 4'b0000);

        // Unfrozen, the same ADD now writes 0100
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("post freeze status", status, 4'b0100);

        // Save 0110, overwrite with 1001, restore alongside s_update
        set_op(SUB, 32'd5, 32'd5, 32'd0, 1'b1);
        cycle();
        check("pre save status", status, 4'b0110);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("save saved", saved_status, 4'b0110);
        check("save status", status, 4'b0110);
        set_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("after save add", status, 4'b1001);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        #1 check("restore next", status_next, 4'b0110);
        cycle();
        check("restore status", status, 4'b0110);
        check("restore saved", saved_status, 4'b0110);
        check("restore changed", {3'b000, flags_changed}, 4'b0001);

        // Build status=1000, saved=0011, then swap
        set_op(SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("sub ovf status", status, 4'b0011);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        set_op(ADD, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("swap pre status", status, 4'b1000);
        check("swap pre saved", saved_status, 4'b0011);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        check("swap status", status, 4'b0011);
        check("swap saved", saved_status, 4'b1000);

        // Frozen save/restore must not touch either register
        set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        check("frozen swap status", status, 4'b0011);
        check("frozen swap saved", saved_status, 4'b1000);

        // Async reset mid-cycle with an update pending
        set_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async rst status", status, 4'b0000);
        check("async rst saved", saved_status, 4'b0000);
        check("async rst changed", {3'b000, flags_changed}, 4'b0000);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        cycle();
        check("post rst status", status, 4'b0000);
        check("post rst saved", saved_status, 4'b0000);
        check("post rst changed", {3'b000, flags_changed}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_flag_register.md
# status_flag_register

Producer side of the NZCV status path in the EXE stage: derives N, Z, C, V from the current ALU operation and holds them in the architectural status register that the condition-check logic reads. Updates are gated by the instruction's S bit and the pipeline freeze; a one-entry shadow copy supports exception entry/return. Output bit order is {N, Z, C, V}, matching the consumer's `status[3:0]` input.

## Interface
- `WIDTH`, default 32: datapath width of operands and ALU result.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low.
- `alu_cmd`  in  4  EXE command: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000; any other code is treated as logical.
- `op_a`  in  WIDTH  ALU first operand (Rn).
- `op_b`  in  WIDTH  ALU second operand (shifter output).
- `alu_result`  in  WIDTH  ALU result for the same instruction.
- `alu_carry`  in  1  ALU carry-out (for SUB/SBC: 1 = no borrow).
- `s_update`  in  1  instruction valid and S bit set.
- `freeze`  in  1  pipeline stall; blocks every register write this cycle.
- `exc_save`  in  1  copy current status into shadow.
- `exc_restore`  in  1  copy shadow into status.
- `status`  out  4  registered {N,Z,C,V}.
- `status_next`  out  4  combinational value `status` takes at the next edge.
- `saved_status`  out  4  registered shadow {N,Z,C,V}.
- `flags_changed`  out  1  registered pulse: `status` changed value at the last edge.

## Operation
- Flag derivation (combinational, from current inputs):
  - N = `alu_result[WIDTH-1]`; Z = (`alu_result` == 0).
  - Arithmetic (ADD, ADC, SUB, SBC): C = `alu_carry`.
  - Add-type (ADD, ADC): V = (a_msb == b_msb) & (r_msb != a_msb).
  - Sub-type (SUB, SBC): V = (a_msb != b_msb) & (r_msb != a_msb).
  - Logical/move (MOV, MVN, AND, ORR, EOR, others): C and V keep their registered values.
- Write priority at each rising edge, evaluated top-down:
  - `freeze`=1: status and shadow hold; `flags_changed` := 0.
  - `exc_restore`=1: status := `saved_status`. `s_update` is ignored.
  - else `s_update`=1: status := derived flags.
  - else status holds.
- Shadow:
  - `exc_save`=1 with `freeze`=0 loads the pre-edge `status`, not the value being written at the same edge.
  - With `exc_save` and `exc_restore` both set, both actions occur: shadow and status swap.
- `status_next` mirrors the selected write source, including freeze and priority. The value on it always equals `status` after the next edge.
- `flags_changed` := (`status_next` != `status`) & ~`freeze`.

## Timing
- Reset (`rst`=0, asynchronous): `status`=4'b0000, `saved_status`=4'b0000, `flags_changed`=0, effective immediately and independent of `clk`.
- Deassertion of `rst` is synchronised externally. The first edge with `rst`=1 may update state.
- Latency:
  - An S-instruction presented in cycle t is visible on `status` in cycle t+1.
  - It is visible on `status_next` in cycle t, in the same cycle as the inputs.
- Reset asserted mid-operation discards any pending update and the shadow contents.
- Back-to-back `s_update` cycles each write. A C/V hold on a logical op uses the value written at the preceding edge.
- `freeze` held for N cycles delays every pending action by N cycles. No action is queued or lost: the inputs are expected to remain stable while frozen.
- No combinational path from `status` to any input.

## Test plan
- Reset, then ADD with `s_update`=1, `op_a`=0x7FFFFFFF, `op_b`=1, `alu_result`=0x80000000, `alu_carry`=0 -> next cycle `status`=4'b1001 and `flags_changed`=1.
- SUB with `op_a`=5, `op_b`=5, `alu_result`=0, `alu_carry`=1 -> `status`=4'b0110. Then AND with `alu_result`=0xF0000000 -> `status`=4'b1010 (N=1, Z=0, C and V kept).
- ADD that would write 4'b0100 while `s_update`=0 -> `status` unchanged, `flags_changed`=0. The same ADD with `freeze`=1 and `s_update`=1 also leaves `status` unchanged.
- With `status`=4'b0110, pulse `exc_save`. Then an ADD writes 4'b1001. Then pulse `exc_restore` together with `s_update`=1 -> `saved_status`=4'b0110 and `status` returns to 4'b0110.
- With `status`=4'b1000 and `saved_status`=4'b0011, assert `exc_save` and `exc_restore` in the same cycle -> `status`=4'b0011 and `saved_status`=4'b1000.
- Assert `rst`=0 between clock edges while an update is pending -> all outputs 0 immediately. The first edge after release with `s_update`=0 keeps 4'b0000.
